// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state encoding and defaults for the CPU run controller
package cpu_run_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int CYCLE_W_DEF     = 32;
  localparam int HALT_STABLE_DEF = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_STEP = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_TOUT = 3'd4;

endpackage

// File: rtl/cpu_halt_detect.sv
// rtl/cpu_halt_detect.sv - probe match / stability halt detector, sampled on enabled cycles
module cpu_halt_detect
  import cpu_run_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int HALT_STABLE = HALT_STABLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              restart_i,
  input  logic              cpu_en_i,
  input  logic              match_en_i,
  input  logic              stable_en_i,
  input  logic [DATA_W-1:0] halt_value_i,
  input  logic [DATA_W-1:0] probe_i,
  output logic              halt_hit_o
);

  localparam int SW = $clog2(HALT_STABLE) + 1;

  logic [DATA_W-1:0] prev_probe_q;
  logic [SW-1:0]     stable_cnt_q, stable_cnt_d;
  logic [SW:0]       stable_inc;
  logic              same, match_hit, stable_hit;

  assign same       = (probe_i == prev_probe_q);
  assign stable_inc = {1'b0, stable_cnt_q} + (SW+1)'(1);
  assign match_hit  = match_en_i && (probe_i == halt_value_i);
  // stable_inc counts this sample too, so HALT_STABLE-1 repeats mean HALT_STABLE equal samples
  assign stable_hit = stable_en_i && same && (stable_inc >= (SW+1)'(HALT_STABLE - 1));
  assign halt_hit_o = cpu_en_i && (match_hit || stable_hit);

  always_comb begin
    stable_cnt_d = '0;
    if (same) begin
      stable_cnt_d = (&stable_cnt_q) ? stable_cnt_q : stable_inc[SW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      prev_probe_q <= '0;
      stable_cnt_q <= '0;
    end else if (restart_i) begin
      stable_cnt_q <= '0;
    end else if (cpu_en_i) begin
      prev_probe_q <= probe_i;
      stable_cnt_q <= stable_cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/pause controller gating the CPU clock enable and counting cycles
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CYCLE_W     = CYCLE_W_DEF,
  parameter int HALT_STABLE = HALT_STABLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic               pause,
  input  logic               clear,
  input  logic               match_en,
  input  logic               stable_en,
  input  logic [DATA_W-1:0]  halt_value,
  input  logic [CYCLE_W-1:0] cycle_budget,
  input  logic [DATA_W-1:0]  probe,
  output logic               cpu_en,
  output logic [CYCLE_W-1:0] cycle_cnt,
  output logic               done,
  output logic               timeout,
  output logic [DATA_W-1:0]  result
);

  logic [2:0]         state_q, state_d;
  logic [CYCLE_W-1:0] cnt_q, cnt_d;
  logic [CYCLE_W:0]   cnt_inc;
  logic               done_q, done_d, tout_q, tout_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               halt_hit, budget_hit, restart;

  assign cpu_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cnt_inc    = {1'b0, cnt_q} + (CYCLE_W+1)'(1);
  assign budget_hit = cpu_en && (cycle_budget != '0) && (cnt_inc == {1'b0, cycle_budget});
  assign restart    = !clear && start && ((state_q == ST_DONE) || (state_q == ST_TOUT));

  cpu_halt_detect #(
    .DATA_W      (DATA_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt_detect (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .restart_i    (restart),
    .cpu_en_i     (cpu_en),
    .match_en_i   (match_en),
    .stable_en_i  (stable_en),
    .halt_value_i (halt_value),
    .probe_i      (probe),
    .halt_hit_o   (halt_hit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    tout_d   = tout_q;
    result_d = result_q;
    if (cpu_en) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CYCLE_W-1:0];
    end
    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      tout_d   = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_RUN, ST_STEP: begin
          // halt outranks budget, and a halt on the single STEP edge still lands in DONE
          if (halt_hit) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = probe;
          end else if (budget_hit) begin
            state_d  = ST_TOUT;
            tout_d   = 1'b1;
            result_d = probe;
          end else if (state_q == ST_STEP || pause) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (start && !pause) state_d = ST_RUN;
          else if (step)       state_d = ST_STEP;
        end
        ST_DONE, ST_TOUT: begin
          if (start) begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            tout_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      result_q <= result_d;
    end
  end

  assign cycle_cnt = cnt_q;
  assign done      = done_q;
  assign timeout   = tout_q;
  assign result    = result_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed vector and sequence bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, step, pause, clear, match_en, stable_en;
  logic [31:0] halt_value, cycle_budget, probe;
  logic        cpu_en, done, timeout;
  logic [31:0] cycle_cnt, result;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          probe_mode = 0;
  logic [31:0] cpu_cyc;

  typedef struct {
    logic clear, start, step, pause;
    logic exp_en;
    int   exp_cnt;
  } vec_t;
  vec_t vecs[15];

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .pause(pause), .clear(clear),
    .match_en(match_en), .stable_en(stable_en), .halt_value(halt_value),
    .cycle_budget(cycle_budget), .probe(probe), .cpu_en(cpu_en), .cycle_cnt(cycle_cnt),
    .done(done), .timeout(timeout), .result(result)
  );

  always #5 clk = ~clk;

  // stand-in CPU: advances only on enabled cycles; k is the enabled cycle being executed
  always @(posedge clk) begin
    if (rst || clear) cpu_cyc <= 32'd0;
    else if (cpu_en)  cpu_cyc <= cpu_cyc + 32'd1;
  end

  always_comb begin
    logic [31:0] k;
    k = cpu_cyc + 32'd1;
    probe = 32'd1000 + k;
    case (probe_mode)
      1: if (k == 32'd40) probe = 32'h37;
      2: if (k >= 32'd20) probe = 32'd5;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_until(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!(done || timeout) && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, (n < max_cycles), 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int en_pulses;
    rst = 1'b1; start = 0; step = 0; pause = 0; clear = 0;
    match_en = 0; stable_en = 0; halt_value = 32'h37; cycle_budget = 0;
    cpu_cyc = 0;

    vecs[0]  = '{1, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 1, 2};
    vecs[4]  = '{0, 0, 1, 0, 1, 3};
    vecs[5]  = '{0, 0, 0, 1, 0, 4};
    vecs[6]  = '{0, 1, 0, 1, 0, 4};
    vecs[7]  = '{0, 0, 1, 0, 1, 4};
    vecs[8]  = '{0, 0, 1, 0, 0, 5};
    vecs[9]  = '{0, 1, 1, 0, 1, 5};
    vecs[10] = '{0, 0, 0, 0, 1, 6};
    vecs[11] = '{1, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 1, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 1};

    tick(); tick();
    check("rst_cpu_en", cpu_en, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    start = 1'b1;
    check("start_pre_en", cpu_en, 0);
    tick();
    start = 1'b0;
    check("start_en_rise", cpu_en, 1);
    check("start_cnt0", cycle_cnt, 0);
    repeat (10) tick();
    check("run10_cnt", cycle_cnt, 10);

    for (int i = 0; i < 15; i++) begin
      clear = vecs[i].clear; start = vecs[i].start; step = vecs[i].step; pause = vecs[i].pause;
      tick();
      clear = 0; start = 0; step = 0; pause = 0;
      check($sformatf("vec%0d_en", i), cpu_en, vecs[i].exp_en);
      check($sformatf("vec%0d_cnt", i), cycle_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_flags", i), {done, timeout}, 2'b00);
    end

    match_en = 1; probe_mode = 1;
    do_clear();
    start = 1; tick(); start = 0;
    run_until("match_bound", 100);
    check("match_done", done, 1);
    check("match_timeout", timeout, 0);
    check("match_result", result, 32'h37);
    check("match_cnt", cycle_cnt, 40);
    check("match_en_low", cpu_en, 0);
    tick();
    check("match_hold_cnt", cycle_cnt, 40);
    check("match_hold_done", done, 1);

    match_en = 0; probe_mode = 0; cycle_budget = 32'd2500;
    do_clear();
    start = 1; tick(); start = 0;
    run_until("budget_bound", 3000);
    check("budget_timeout", timeout, 1);
    check("budget_done", done, 0);
    check("budget_cnt", cycle_cnt, 2500);
    check("budget_result", result, 3500);
    check("budget_en_low", cpu_en, 0);
    start = 1; tick(); start = 0;
    check("restart_tout_clr", timeout, 0);
    check("restart_en", cpu_en, 1);
    check("restart_cnt_kept", cycle_cnt, 2500);
    tick();
    check("restart_cnt_inc", cycle_cnt, 2501);

    cycle_budget = 0; stable_en = 1; probe_mode = 2;
    do_clear();
    start = 1; tick(); start = 0;
    run_until("stable_bound", 100);
    check("stable_done", done, 1);
    check("stable_cnt", cycle_cnt, 27);
    check("stable_result", result, 5);

    stable_en = 0; probe_mode = 0;
    do_clear();
    start = 1; tick(); start = 0;
    repeat (14) tick();
    pause = 1; tick();
    check("pause_cnt", cycle_cnt, 15);
    check("pause_en", cpu_en, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("paused%0d_cnt", i), cycle_cnt, 15);
    end
    pause = 0;
    en_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step = 1; tick(); step = 0;
      if (cpu_en) en_pulses++;
      tick();
      if (cpu_en) en_pulses++;
    end
    check("step_pulses", en_pulses, 3);
    check("step_cnt", cycle_cnt, 18);
    start = 1; tick(); start = 0;
    tick();
    check("resume_cnt", cycle_cnt, 19);
    check("resume_en", cpu_en, 1);

    match_en = 1; probe_mode = 1; cycle_budget = 32'd40;
    do_clear();
    start = 1; tick(); start = 0;
    repeat (38) tick();
    pause = 1; tick(); pause = 0;
    check("tie_pre_cnt", cycle_cnt, 39);
    step = 1; tick(); step = 0;
    check("tie_step_en", cpu_en, 1);
    tick();
    check("tie_done", done, 1);
    check("tie_timeout", timeout, 0);
    check("tie_cnt", cycle_cnt, 40);
    check("tie_en_low", cpu_en, 0);
    check("tie_result", result, 32'h37);

    start = 1; tick(); start = 0;
    check("redo_done_clr", done, 0);
    check("redo_en", cpu_en, 1);
    repeat (3) tick();
    check("redo_cnt", cycle_cnt, 43);
    rst = 1; tick(); rst = 0;
    check("midrst_en", cpu_en, 0);
    check("midrst_cnt", cycle_cnt, 0);
    check("midrst_flags", {done, timeout}, 2'b00);
    check("midrst_result", result, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
